// File: rtl/addcmp_arbiter_pkg.sv
// Shared definitions for the two-requester add/compare arbiter:
// state encoding, default operand width and the round-robin decision helper.
package addcmp_arbiter_pkg;

    localparam int DEF_WIDTH = 4;

    // 2'b11 is unused and recovers to IDLE on the next edge.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        RESP  = 2'b10
    } state_t;

    // Returns {found, winner}; on a tie the requester that was not served last wins.
    function automatic logic [1:0] arbitrate(input logic req0, input logic req1, input logic last);
        logic found;
        logic winner;
        found  = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else begin
            winner = req1;
        end
        return {found, winner};
    endfunction

endpackage

// File: rtl/addcmp_arbiter_if.sv
// Requester-side bundle of the add/compare arbiter: two request/operand sets
// in, grant/valid strobes and the shared registered result out.
interface addcmp_arbiter_if
    import addcmp_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] f0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] f1;
    logic             gnt0;
    logic             gnt1;
    logic             valid0;
    logic             valid1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             eq;
    logic             gt;
    logic             lt;

    modport slave (
        input  req0, a0, b0, f0, req1, a1, b1, f1,
        output gnt0, gnt1, valid0, valid1, sum, cout, eq, gt, lt
    );

    modport master (
        output req0, a0, b0, f0, req1, a1, b1, f1,
        input  gnt0, gnt1, valid0, valid1, sum, cout, eq, gt, lt
    );

endinterface

// File: rtl/addcmp_arbiter_addcmp_unit.sv
// Combinational shared datapath: ripple-carry adder followed by an unsigned
// magnitude comparator of the truncated sum against the target f.
module addcmp_unit
    import addcmp_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    logic [WIDTH:0] carry_s;
    logic           gt_acc_s;
    logic           lt_acc_s;

    // Ripple adder, one full-adder cell per bit.
    always_comb begin
        carry_s    = '0;
        s          = '0;
        carry_s[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        co = carry_s[WIDTH];
    end

    // Magnitude comparator scanned LSB to MSB so higher bits override lower ones.
    always_comb begin
        gt_acc_s = 1'b0;
        lt_acc_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            gt_acc_s = (s[i] & ~f[i]) | (~(s[i] ^ f[i]) & gt_acc_s);
            lt_acc_s = (~s[i] & f[i]) | (~(s[i] ^ f[i]) & lt_acc_s);
        end
        gt = gt_acc_s;
        lt = lt_acc_s;
        eq = ~gt_acc_s & ~lt_acc_s;
    end

endmodule

// File: rtl/dff_ar.sv
// Flip-flop bank with asynchronous active-high reset to a fixed value.
module dff_ar #(
    parameter int         W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // State element: reset value applies immediately on rst, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/addcmp_arbiter.sv
// Round-robin arbiter/sequencer sharing one add/compare unit between two
// requesters: IDLE -> GRANT (operands sampled at its end) -> RESP (valid pulse).
module addcmp_arbiter
    import addcmp_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    addcmp_arbiter_if.slave  bus
);

    localparam int RW = WIDTH + 4;

    logic [1:0]       state_bits_r;
    state_t           state_r;
    state_t           next_state_s;
    logic             owner_r;
    logic             next_owner_s;
    logic             last_r;
    logic             next_last_s;
    logic             capture_s;
    logic [1:0]       arb_s;
    logic             owner_req_s;

    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [WIDTH-1:0] sel_f_s;
    logic [WIDTH-1:0] u_s;
    logic             u_co;
    logic             u_eq;
    logic             u_gt;
    logic             u_lt;
    logic [RW-1:0]    res_r;
    logic [RW-1:0]    res_d_s;

    assign state_r = state_t'(state_bits_r);

    dff_ar #(.W(2), .RST_VAL(2'b00)) u_state_reg (
        .clk (clk), .rst (rst), .d (next_state_s), .q (state_bits_r)
    );
    dff_ar #(.W(1), .RST_VAL(1'b0)) u_owner_reg (
        .clk (clk), .rst (rst), .d (next_owner_s), .q (owner_r)
    );
    dff_ar #(.W(1), .RST_VAL(1'b1)) u_last_reg (
        .clk (clk), .rst (rst), .d (next_last_s), .q (last_r)
    );
    dff_ar #(.W(RW), .RST_VAL({RW{1'b0}})) u_res_reg (
        .clk (clk), .rst (rst), .d (res_d_s), .q (res_r)
    );

    // Operand steering: only the current owner's operands reach the datapath.
    always_comb begin
        if (owner_r) begin
            sel_a_s     = bus.a1;
            sel_b_s     = bus.b1;
            sel_f_s     = bus.f1;
            owner_req_s = bus.req1;
        end else begin
            sel_a_s     = bus.a0;
            sel_b_s     = bus.b0;
            sel_f_s     = bus.f0;
            owner_req_s = bus.req0;
        end
    end

    addcmp_unit #(.WIDTH(WIDTH)) u_unit (
        .a  (sel_a_s),
        .b  (sel_b_s),
        .f  (sel_f_s),
        .s  (u_s),
        .co (u_co),
        .eq (u_eq),
        .gt (u_gt),
        .lt (u_lt)
    );

    assign arb_s = arbitrate(bus.req0, bus.req1, last_r);

    // Next-state logic; RESP re-arbitrates so back-to-back service needs no IDLE bubble.
    always_comb begin
        next_state_s = state_r;
        next_owner_s = owner_r;
        next_last_s  = last_r;
        capture_s    = 1'b0;
        case (state_r)
            IDLE, RESP: begin
                if (arb_s[1]) begin
                    next_state_s = GRANT;
                    next_owner_s = arb_s[0];
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT: begin
                if (owner_req_s) begin
                    capture_s    = 1'b1;
                    next_last_s  = owner_r;
                    next_state_s = RESP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Result register holds until the next successful capture.
    always_comb begin
        if (capture_s) begin
            res_d_s = {u_s, u_co, u_eq, u_gt, u_lt};
        end else begin
            res_d_s = res_r;
        end
    end

    assign bus.gnt0   = (state_r == GRANT) & ~owner_r;
    assign bus.gnt1   = (state_r == GRANT) &  owner_r;
    assign bus.valid0 = (state_r == RESP)  & ~owner_r;
    assign bus.valid1 = (state_r == RESP)  &  owner_r;
    assign bus.sum    = res_r[RW-1:4];
    assign bus.cout   = res_r[3];
    assign bus.eq     = res_r[2];
    assign bus.gt     = res_r[1];
    assign bus.lt     = res_r[0];

endmodule

// File: tb/tb_addcmp_arbiter.sv
// Directed plus randomized bench for addcmp_arbiter, checked cycle by cycle
// against a transaction-level reference model.
module tb_addcmp_arbiter;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // reference model: who holds a grant / gets a result this cycle (-1 = nobody)
    int         m_grant;
    int         m_resp;
    int         m_last;
    logic [W-1:0] e_sum;
    logic       e_cout;
    logic       e_eq;
    logic       e_gt;
    logic       e_lt;

    addcmp_arbiter_if #(.WIDTH(W)) bus ();

    addcmp_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_grant = -1;
        m_resp  = -1;
        m_last  = 1;
        e_sum   = '0;
        e_cout  = 1'b0;
        e_eq    = 1'b0;
        e_gt    = 1'b0;
        e_lt    = 1'b0;
    endtask

    task automatic model_capture(input int a, input int b, input int f);
        int s;
        s      = a + b;
        e_sum  = W'(s % (1 << W));
        e_cout = (s >= (1 << W));
        e_eq   = ((s % (1 << W)) == f);
        e_gt   = ((s % (1 << W)) >  f);
        e_lt   = ((s % (1 << W)) <  f);
    endtask

    // Advance the model by one clock edge using the inputs presented to that edge.
    task automatic model_step();
        int g;
        int r;
        g = -1;
        r = -1;
        if (m_grant == 0) begin
            if (bus.req0) begin
                model_capture(int'(bus.a0), int'(bus.b0), int'(bus.f0));
                m_last = 0;
                r = 0;
            end
        end else if (m_grant == 1) begin
            if (bus.req1) begin
                model_capture(int'(bus.a1), int'(bus.b1), int'(bus.f1));
                m_last = 1;
                r = 1;
            end
        end else begin
            if (bus.req0 && bus.req1) g = 1 - m_last;
            else if (bus.req0)        g = 0;
            else if (bus.req1)        g = 1;
        end
        m_grant = g;
        m_resp  = r;
    endtask

    task automatic check_all(input string phase);
        chk({phase, ".gnt0"},   8'(bus.gnt0),   8'(m_grant == 0));
        chk({phase, ".gnt1"},   8'(bus.gnt1),   8'(m_grant == 1));
        chk({phase, ".valid0"}, 8'(bus.valid0), 8'(m_resp == 0));
        chk({phase, ".valid1"}, 8'(bus.valid1), 8'(m_resp == 1));
        chk({phase, ".sum"},    8'(bus.sum),    8'(e_sum));
        chk({phase, ".cout"},   8'(bus.cout),   8'(e_cout));
        chk({phase, ".eq"},     8'(bus.eq),     8'(e_eq));
        chk({phase, ".gt"},     8'(bus.gt),     8'(e_gt));
        chk({phase, ".lt"},     8'(bus.lt),     8'(e_lt));
    endtask

    task automatic tick(input string phase);
        model_step();
        @(posedge clk);
        #1;
        check_all(phase);
    endtask

    // Assert rst between edges and check outputs clear with no clock edge.
    task automatic async_reset(input string phase);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(phase);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_req0(input logic r, input int a, input int b, input int f);
        bus.req0 = r;
        bus.a0   = W'(a);
        bus.b0   = W'(b);
        bus.f0   = W'(f);
    endtask

    task automatic set_req1(input logic r, input int a, input int b, input int f);
        bus.req1 = r;
        bus.a1   = W'(a);
        bus.b1   = W'(b);
        bus.f1   = W'(f);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        set_req0(1'b0, 0, 0, 0);
        set_req1(1'b0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        tick("idle");
        tick("idle");

        // single request 3+4 vs 7
        set_req0(1'b1, 3, 4, 7);
        tick("single_g");
        chk("single_gnt0", 8'(bus.gnt0), 8'd1);
        tick("single_v");
        chk("single_sum", 8'(bus.sum), 8'd7);
        chk("single_eq", 8'(bus.eq), 8'd1);
        set_req0(1'b0, 3, 4, 7);
        tick("single_end");
        tick("single_idle");

        // overflow 9+8 vs 0
        set_req1(1'b1, 9, 8, 0);
        tick("ovf_g");
        tick("ovf_v");
        chk("ovf_sum", 8'(bus.sum), 8'd1);
        chk("ovf_cout", 8'(bus.cout), 8'd1);
        chk("ovf_gt", 8'(bus.gt), 8'd1);
        set_req1(1'b0, 9, 8, 0);
        tick("ovf_end");

        // contention from reset: grants must alternate starting with req0
        async_reset("rst_idle");
        set_req0(1'b1, 1, 1, 2);
        set_req1(1'b1, 5, 5, 15);
        for (int i = 0; i < 12; i++) tick("contend");
        set_req0(1'b0, 1, 1, 2);
        set_req1(1'b0, 5, 5, 15);
        tick("contend_end");
        tick("contend_end");
        tick("contend_end");

        // abort: req0 drops during its grant cycle, results must hold
        set_req0(1'b1, 7, 7, 1);
        tick("abort_g");
        set_req0(1'b0, 7, 7, 1);
        tick("abort_drop");
        chk("abort_valid0", 8'(bus.valid0), 8'd0);
        set_req1(1'b1, 2, 3, 9);
        tick("after_abort_g");
        tick("after_abort_v");
        set_req1(1'b0, 2, 3, 9);
        tick("after_abort_end");

        // async reset while a result is being presented
        set_req0(1'b1, 6, 6, 12);
        tick("mid_g");
        tick("mid_v");
        async_reset("mid_rst");
        chk("mid_rst_valid0", 8'(bus.valid0), 8'd0);
        set_req1(1'b1, 4, 4, 4);
        tick("post_rst_tie");
        chk("post_rst_gnt0", 8'(bus.gnt0), 8'd1);
        tick("post_rst");

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            set_req0(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            set_req1(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
